// File: rtl/decrement_module.sv
// Combinational decrement stage: out = in - 1 via in + all-ones.
// carry_out is 1 for any nonzero input and 0 only when in == 0.
module decrement_module #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
);

    // Adding all-ones subtracts one; the carry marks a nonzero input.
    always_comb begin
        {carry_out, out} = {1'b0, in} + {1'b0, {WIDTH{1'b1}}};
    end

endmodule

// File: rtl/loop_counter.sv
// Loadable down-counter with a programmable tick rate and a done handshake.
// Wraps decrement_module; used for loop instructions and timed waits.
module loop_counter #(
    parameter int unsigned WIDTH    = 20,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  count_n;
    logic [PW-1:0]     pre, pre_n;
    logic [WIDTH-1:0]  dec_out;
    logic              dec_carry;
    logic [WIDTH-1:0]  eff_value;
    logic              tick;

    decrement_module #(.WIDTH(WIDTH)) u_dec (
        .in        (count),
        .out       (dec_out),
        .carry_out (dec_carry)
    );

    // State, count and prescale registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            pre   <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            pre   <= pre_n;
        end
    end

    // Next-state, next-count and prescale logic.
    always_comb begin
        state_n   = state;
        count_n   = count;
        pre_n     = pre;
        eff_value = load ? load_value : count;
        tick      = (pre == PRE_LAST);
        unique case (state)
            IDLE: begin
                if (load) count_n = load_value;
                if (start) begin
                    if (eff_value != '0) begin
                        state_n = RUN;
                        pre_n   = '0;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort beats a coincident tick: count stays frozen.
                    state_n = IDLE;
                    pre_n   = '0;
                end else if (tick) begin
                    pre_n = '0;
                    // A zero count never reaches a tick; treat it as terminal.
                    if (dec_carry) count_n = dec_out;
                    if (!dec_carry || dec_out == '0) state_n = DONE;
                end else begin
                    pre_n = pre + PW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status decoded directly from the state and count registers.
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign zero = (count == '0);

endmodule

// File: tb/tb_loop_counter.sv
// Bench for loop_counter: two instances (PRESCALE 1 and 4) share stimulus
// and are compared every cycle against an elapsed-time reference model.
module tb_loop_counter;

    localparam int unsigned W = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;

    logic [W-1:0]  count_a, count_b;
    logic          busy_a, busy_b, done_a, done_b, zero_a, zero_b;

    int checks = 0;
    int errors = 0;

    // Reference model per instance: 0 = idle, 1 = running, 2 = done pulse.
    int          m_mode  [2];
    int unsigned m_count [2];
    int unsigned m_n     [2];
    longint      m_el    [2];
    int unsigned m_pre   [2] = '{1, 4};

    loop_counter #(.WIDTH(W), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .abort(abort),
        .count(count_a), .busy(busy_a), .done(done_a), .zero(zero_a)
    );

    loop_counter #(.WIDTH(W), .PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .abort(abort),
        .count(count_b), .busy(busy_b), .done(done_b), .zero(zero_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_count[i] = 0; m_n[i] = 0; m_el[i] = 0;
        end
    endtask

    // One clock edge of the behavioural rules, from the inputs held at the edge.
    task automatic model_step();
        int unsigned eff;
        for (int i = 0; i < 2; i++) begin
            case (m_mode[i])
                0: begin
                    eff = load ? 32'(load_value) : m_count[i];
                    if (load) m_count[i] = 32'(load_value);
                    if (start) begin
                        if (eff != 0) begin
                            m_mode[i] = 1; m_n[i] = eff; m_el[i] = 0;
                        end else begin
                            m_mode[i] = 2;
                        end
                    end
                end
                1: begin
                    if (abort) begin
                        m_mode[i] = 0;
                    end else begin
                        m_el[i]++;
                        m_count[i] = m_n[i] - 32'(m_el[i] / longint'(m_pre[i]));
                        if (m_el[i] == longint'(m_n[i]) * longint'(m_pre[i])) m_mode[i] = 2;
                    end
                end
                default: m_mode[i] = 0;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count1"}, 32'(count_a), m_count[0]);
        check({tag, ".busy1"},  32'(busy_a),  32'(m_mode[0] == 1));
        check({tag, ".done1"},  32'(done_a),  32'(m_mode[0] == 2));
        check({tag, ".zero1"},  32'(zero_a),  32'(m_count[0] == 0));
        check({tag, ".count4"}, 32'(count_b), m_count[1]);
        check({tag, ".busy4"},  32'(busy_b),  32'(m_mode[1] == 1));
        check({tag, ".done4"},  32'(done_b),  32'(m_mode[1] == 2));
        check({tag, ".zero4"},  32'(zero_b),  32'(m_count[1] == 0));
    endtask

    task automatic cyc(input string tag, input logic l, input logic [W-1:0] v,
                       input logic s, input logic a);
        load = l; load_value = v; start = s; abort = a;
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cycles;
        logic [W-1:0] rv;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: load 3 then start; also counts busy cycles at PRESCALE=1.
        cyc("t1_load", 1'b1, 20'd3, 1'b0, 1'b0);
        cyc("t1_start", 1'b0, '0, 1'b1, 1'b0);
        busy_cycles = 0;
        for (int k = 0; k < 14; k++) begin
            if (busy_a) busy_cycles++;
            cyc("t1_run", 1'b0, '0, 1'b0, 1'b0);
        end
        check("t1_busy_len", 32'(busy_cycles), 32'd3);

        // 2: load 2, start; PRESCALE=4 instance stays busy 8 cycles.
        cyc("t2_load", 1'b1, 20'd2, 1'b0, 1'b0);
        cyc("t2_start", 1'b0, '0, 1'b1, 1'b0);
        busy_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy_b) busy_cycles++;
            cyc("t2_run", 1'b0, '0, 1'b0, 1'b0);
        end
        check("t2_busy_len", 32'(busy_cycles), 32'd8);

        // 3: simultaneous load and start uses the new value.
        cyc("t3_load9", 1'b1, 20'h00009, 1'b0, 1'b0);
        cyc("t3_ldst", 1'b1, 20'h00005, 1'b1, 1'b0);
        check("t3_from5", 32'(count_a), 32'h5);
        idle("t3_run", 24);

        // 4: start with zero count goes straight to the done pulse.
        cyc("t4_load0", 1'b1, 20'h0, 1'b0, 1'b0);
        cyc("t4_start", 1'b0, '0, 1'b1, 1'b0);
        check("t4_done", 32'(done_a), 32'd1);
        idle("t4_after", 3);

        // 5: abort freezes count; abort beats the final tick.
        cyc("t5_load", 1'b1, 20'hFFFFF, 1'b0, 1'b0);
        cyc("t5_start", 1'b0, '0, 1'b1, 1'b0);
        idle("t5_run", 10);
        cyc("t5_abort", 1'b0, '0, 1'b0, 1'b1);
        check("t5_frozen", 32'(count_a), 32'hFFFF5);
        idle("t5_idle", 3);
        cyc("t5b_load", 1'b1, 20'd1, 1'b0, 1'b0);
        cyc("t5b_start", 1'b0, '0, 1'b1, 1'b0);
        cyc("t5b_abort", 1'b0, '0, 1'b0, 1'b1);
        check("t5b_count", 32'(count_a), 32'd1);
        idle("t5b_idle", 3);

        // 6a: load/start while busy are ignored.
        cyc("t6_load", 1'b1, 20'd7, 1'b0, 1'b0);
        cyc("t6_start", 1'b0, '0, 1'b1, 1'b0);
        cyc("t6_ign1", 1'b1, 20'h33, 1'b1, 1'b0);
        cyc("t6_ign2", 1'b1, 20'h33, 1'b1, 1'b0);
        idle("t6_run", 32);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rv = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            cyc("rnd", ($urandom_range(0, 5) == 0), rv,
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0));
        end
        cyc("rnd_abort", 1'b0, '0, 1'b0, 1'b1);
        idle("rnd_tail", 4);

        // 6b: asynchronous reset between edges while running at 0x40.
        cyc("t6b_load", 1'b1, 20'h50, 1'b0, 1'b0);
        cyc("t6b_start", 1'b0, '0, 1'b1, 1'b0);
        idle("t6b_run", 16);
        check("t6b_at40", 32'(count_a), 32'h40);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("t6b_async");
        #2;
        rst = 1'b0;
        idle("t6b_after", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
